// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Sequencing and time-set controller for the hour:min:sec clock top.
//   RUN      : produces a one-cycle `enable` strobe every TICK_DIV clocks.
//   SET_HOUR : counting frozen, inc/dec edit the hour shadow register.
//   SET_MIN  : as above, minute field.
//   SET_SEC  : as above, second field; a mode press returns to RUN and
//              issues a one-cycle `load` with the edited values on data_*.
// Any SET state is abandoned (no load) after TIMEOUT_TICKS*TICK_DIV clocks
// without a button press.
//
// Ports
//   clock      in   system clock, rising edge
//   reset_n    in   asynchronous reset, ACTIVE-HIGH (name matches clock top)
//   btn_mode   in   mode button level (already synchronised)
//   btn_inc    in   increment button level (already synchronised)
//   btn_dec    in   decrement button level (already synchronised)
//   cur_hour   in   [5:0] current hour from the clock top
//   cur_min    in   [5:0] current minute from the clock top
//   cur_sec    in   [5:0] current second from the clock top
//   enable     out  one-cycle count strobe
//   load       out  one-cycle load strobe
//   data_hour  out  [5:0] hour value to load
//   data_min   out  [5:0] minute value to load
//   data_sec   out  [5:0] second value to load
//   set_state  out  [1:0] 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   blink      out  blink for the field being edited, 0 in RUN
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int TICK_DIV      = 100,
  parameter int TIMEOUT_TICKS = 30,
  parameter int HOUR_MAX      = 23,
  parameter int MS_MAX        = 59
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       enable,
  output logic       load,
  output logic [5:0] data_hour,
  output logic [5:0] data_min,
  output logic [5:0] data_sec,
  output logic [1:0] set_state,
  output logic       blink
);

  localparam int TMO_LIMIT = TIMEOUT_TICKS * TICK_DIV;
  localparam int HALF_DIV  = TICK_DIV / 2;
  localparam int PW        = $clog2(TICK_DIV);
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam int BW        = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_LIMIT - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_DIV - 1);
  localparam logic [5:0]    HOUR_TOP   = 6'(HOUR_MAX);
  localparam logic [5:0]    MS_TOP     = 6'(MS_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;
  logic          mode_q, inc_q, dec_q;
  logic [5:0]    shadow_hour, shadow_min, shadow_sec;
  logic [5:0]    hour_next, min_next, sec_next;

  logic mode_press, inc_press, dec_press, any_press;
  logic timeout_hit, edit_en, in_set;

  // Wrap-around helpers. Values above `top` (possible when capturing an
  // out-of-range cur_*) snap to 0 on increment; decrement never clamps.
  function automatic logic [5:0] wrap_up(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dn(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  // Rising edge on a level button; history resets to 1 so a button held
  // through reset release is not seen as a press.
  assign mode_press = btn_mode & ~mode_q;
  assign inc_press  = btn_inc  & ~inc_q;
  assign dec_press  = btn_dec  & ~dec_q;
  assign any_press  = mode_press | inc_press | dec_press;

  assign in_set      = (state != RUN);
  assign timeout_hit = in_set && !any_press && (tmo_cnt == TMO_LAST);
  // Mode wins over a simultaneous inc/dec; inc+dec together cancel.
  assign edit_en     = in_set && !mode_press && (inc_press ^ dec_press);

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:      if (mode_press) state_next = SET_HOUR;
      SET_HOUR: if (mode_press) state_next = SET_MIN;
                else if (timeout_hit) state_next = RUN;
      SET_MIN:  if (mode_press) state_next = SET_SEC;
                else if (timeout_hit) state_next = RUN;
      SET_SEC:  if (mode_press || timeout_hit) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  // Shadow register next values: capture on entry, edit while setting.
  always_comb begin
    hour_next = shadow_hour;
    min_next  = shadow_min;
    sec_next  = shadow_sec;
    if (state == RUN && mode_press) begin
      hour_next = cur_hour;
      min_next  = cur_min;
      sec_next  = cur_sec;
    end else if (edit_en) begin
      unique case (state)
        SET_HOUR: hour_next = inc_press ? wrap_up(shadow_hour, HOUR_TOP)
                                        : wrap_dn(shadow_hour, HOUR_TOP);
        SET_MIN:  min_next  = inc_press ? wrap_up(shadow_min, MS_TOP)
                                        : wrap_dn(shadow_min, MS_TOP);
        SET_SEC:  sec_next  = inc_press ? wrap_up(shadow_sec, MS_TOP)
                                        : wrap_dn(shadow_sec, MS_TOP);
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      state     <= RUN;
      presc     <= '0;
      tmo_cnt   <= '0;
      blink_cnt <= '0;
      blink     <= 1'b0;
      load      <= 1'b0;
      mode_q    <= 1'b1;
      inc_q     <= 1'b1;
      dec_q     <= 1'b1;
    end else begin
      state  <= state_next;
      mode_q <= btn_mode;
      inc_q  <= btn_inc;
      dec_q  <= btn_dec;

      // Only a mode press out of SET_SEC loads; a timeout exit does not.
      load <= (state == SET_SEC) && mode_press;

      // Prescaler runs only while staying in RUN; it restarts from 0 on
      // the first RUN cycle after any SET exit.
      if (state == RUN && state_next == RUN)
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      else
        presc <= '0;

      if (state_next == RUN || state_next != state || any_press)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);

      // Blink restarts high on entry to each SET state.
      if (state_next == RUN) begin
        blink     <= 1'b0;
        blink_cnt <= '0;
      end else if (state_next != state) begin
        blink     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink     <= ~blink;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      shadow_hour <= '0;
      shadow_min  <= '0;
      shadow_sec  <= '0;
    end else begin
      shadow_hour <= hour_next;
      shadow_min  <= min_next;
      shadow_sec  <= sec_next;
    end
  end

  // load cycle always has presc==0, so enable and load cannot coincide;
  // the !load term makes that explicit.
  assign enable    = (state == RUN) && (presc == PRESC_LAST) && !load;
  assign set_state = state;
  assign data_hour = shadow_hour;
  assign data_min  = shadow_min;
  assign data_sec  = shadow_sec;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl (TICK_DIV=10, TIMEOUT_TICKS=3).
// A cycle-level reference model tracks mode, field values and elapsed-cycle
// counts; outputs are compared each cycle one time unit after the falling
// edge. Directed scenarios are followed by a randomized button/value phase.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  localparam int TD    = 10;
  localparam int TT    = 3;
  localparam int HMAX  = 23;
  localparam int MMAX  = 59;
  localparam int LIMIT = TT * TD;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [5:0] cur_hour = '0, cur_min = '0, cur_sec = '0;
  logic       enable, load, blink;
  logic [5:0] data_hour, data_min, data_sec;
  logic [1:0] set_state;

  clock_set_ctrl #(
    .TICK_DIV      (TD),
    .TIMEOUT_TICKS (TT),
    .HOUR_MAX      (HMAX),
    .MS_MAX        (MMAX)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .enable    (enable),
    .load      (load),
    .data_hour (data_hour),
    .data_min  (data_min),
    .data_sec  (data_sec),
    .set_state (set_state),
    .blink     (blink)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: m_mode 0=RUN 1..3 = field being set.
  int m_mode;
  int m_fld [1:3];     // 1=hour 2=min 3=sec
  int m_idle;          // consecutive press-free cycles in the current SET stay
  int m_set_cyc;       // cycles spent in the current SET state
  int m_run_cyc;       // cycles spent in RUN since entering it
  bit m_load;
  bit m_pm, m_pi, m_pd;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int fmax(input int f);
    return (f == 1) ? HMAX : MMAX;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    for (int f = 1; f <= 3; f++) m_fld[f] = 0;
    m_idle = 0; m_set_cyc = 0; m_run_cyc = 0;
    m_load = 0;
    m_pm = 1; m_pi = 1; m_pd = 1;
  endfunction

  // Advance the model across one rising edge with the given button levels.
  function automatic void model_step(input bit m, input bit i, input bit d);
    bit mp, ip, dp;
    mp = m && !m_pm; ip = i && !m_pi; dp = d && !m_pd;
    m_pm = m; m_pi = i; m_pd = d;
    m_load = (m_mode == 3) && mp;
    if (m_mode == 0) begin
      if (mp) begin
        m_mode = 1;
        m_fld[1] = int'(cur_hour); m_fld[2] = int'(cur_min); m_fld[3] = int'(cur_sec);
        m_set_cyc = 0; m_idle = 0;
      end else begin
        m_run_cyc++;
      end
    end else if (mp) begin
      m_mode = (m_mode == 3) ? 0 : m_mode + 1;
      m_set_cyc = 0; m_idle = 0; m_run_cyc = 0;
    end else begin
      if (ip && !dp)
        m_fld[m_mode] = (m_fld[m_mode] >= fmax(m_mode)) ? 0 : m_fld[m_mode] + 1;
      else if (dp && !ip)
        m_fld[m_mode] = (m_fld[m_mode] == 0) ? fmax(m_mode) : m_fld[m_mode] - 1;
      if (ip || dp) m_idle = 0;
      else m_idle++;
      if (m_idle == LIMIT) begin
        m_mode = 0; m_run_cyc = 0;
      end else begin
        m_set_cyc++;
      end
    end
  endfunction

  task automatic compare_all();
    bit exp_en, exp_blink;
    exp_en    = (m_mode == 0) && !m_load && ((m_run_cyc % TD) == TD - 1);
    exp_blink = (m_mode != 0) && (((m_set_cyc / (TD / 2)) % 2) == 0);
    check("set_state", set_state, m_mode);
    check("load", load, m_load);
    check("enable", enable, exp_en);
    check("blink", blink, exp_blink);
    check("load_enable_excl", load & enable, 0);
    if (m_mode != 0 || m_load) begin
      check("data_hour", data_hour, m_fld[1]);
      check("data_min", data_min, m_fld[2]);
      check("data_sec", data_sec, m_fld[3]);
    end
  endtask

  task automatic tick(input bit m, input bit i, input bit d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    model_step(m, i, d);
    @(negedge clock);
    #1;
    compare_all();
  endtask

  // Assert reset asynchronously (away from any edge), verify the immediate
  // RUN/no-load state, then release on a falling edge.
  task automatic apply_reset(input bit hold_mode);
    btn_mode = hold_mode; btn_inc = 0; btn_dec = 0;
    reset_n = 1'b1;
    #1;
    check("rst_state", set_state, 0);
    check("rst_load", load, 0);
    check("rst_enable", enable, 0);
    check("rst_blink", blink, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    tick(m, i, d);
    tick(0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #3;
    apply_reset(0);

    // Free run: strobes at cycles 9, 19, 29 after release.
    cur_hour = 6'd12; cur_min = 6'd34; cur_sec = 6'd56;
    for (int i = 0; i < 30; i++) begin
      check("en_cycle", enable, (i % 10) == 9);
      tick(0, 0, 0);
    end

    // Enter SET_HOUR, capture 12:34:56.
    tick(1, 0, 0);
    check("enter_state", set_state, 1);
    check("cap_hour", data_hour, 12);
    check("cap_min", data_min, 34);
    check("cap_sec", data_sec, 56);
    check("set_no_enable", enable, 0);
    tick(0, 0, 0);
    repeat (12) press(0, 1, 0);
    check("hour_wrap_up", data_hour, 0);
    press(0, 0, 1);
    check("hour_wrap_dn", data_hour, 23);

    press(1, 0, 0);
    check("to_set_min", set_state, 2);
    repeat (35) press(0, 0, 1);
    check("min_wrap_dn", data_min, 59);
    press(1, 0, 0);
    repeat (4) press(0, 1, 0);
    check("sec_wrap_up", data_sec, 0);

    tick(1, 0, 0);
    check("load_pulse", load, 1);
    check("load_state", set_state, 0);
    check("load_hour", data_hour, 23);
    check("load_min", data_min, 59);
    check("load_sec", data_sec, 0);
    for (int k = 0; k < 10; k++) begin
      check("load_once", load, k == 0);
      check("en_after_load", enable, k == 9);
      tick(0, 0, 0);
    end

    // Mode and inc together in SET_SEC: mode wins, field unchanged.
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    check("in_set_sec", set_state, 3);
    tick(1, 1, 0);
    check("mode_inc_load", load, 1);
    check("mode_inc_state", set_state, 0);
    check("mode_inc_sec", data_sec, 56);
    tick(0, 0, 0);

    // inc and dec together in SET_HOUR: no change.
    press(1, 0, 0);
    tick(0, 1, 1);
    check("inc_dec_cancel", data_hour, 12);
    tick(0, 0, 0);
    repeat (40) tick(0, 0, 0);
    check("timeout_a", set_state, 0);

    // Fresh timeout: exactly LIMIT idle SET cycles, never a load.
    tick(1, 0, 0);
    for (int k = 0; k < LIMIT - 1; k++) begin
      tick(0, 0, 0);
      check("tmo_no_load", load, 0);
    end
    check("tmo_still_set", set_state, 1);
    tick(0, 0, 0);
    check("tmo_exit", set_state, 0);
    check("tmo_exit_load", load, 0);

    // Reset in the middle of an edit.
    press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
    check("pre_reset_state", set_state, 2);
    apply_reset(0);

    // Mode held through reset release is not a press.
    apply_reset(1);
    repeat (3) tick(1, 0, 0);
    check("held_mode_ignored", set_state, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    check("held_mode_repress", set_state, 1);
    tick(0, 0, 0);

    // Randomized phase with idle stretches to provoke timeouts.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        apply_reset($urandom_range(0, 1) == 1);
      end else if ((n % 150) == 75) begin
        repeat (LIMIT + 5) tick(0, 0, 0);
      end else begin
        cur_hour = 6'($urandom_range(0, 63));
        cur_min  = 6'($urandom_range(0, 63));
        cur_sec  = 6'($urandom_range(0, 63));
        tick($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
